// File: rtl/truth_table_sweeper_if.sv
// Handshake/bus bundle between a sweep controller and the truth_table_sweeper.
// Latency: none, wiring only.
// Backpressure: none; start is level-sampled by the sweeper while idle.
interface truth_table_sweeper_if;
   logic       start_i;     // sweep request
   logic [7:0] expected_i;  // reference truth table
   logic       q_i;         // output of the function under test
   logic       a_o;         // vector index MSB
   logic       b_o;         // vector index middle bit
   logic       c_o;         // vector index LSB
   logic       busy_o;      // sweep in progress
   logic       done_o;      // one-cycle completion pulse
   logic [7:0] table_o;     // captured truth table
   logic [7:0] mismatch_o;  // table ^ expected
   logic       pass_o;      // mismatch == 0 after a sweep

   // Control source / function-under-test side
   modport master (
      output start_i, expected_i, q_i,
      input  a_o, b_o, c_o, busy_o, done_o, table_o, mismatch_o, pass_o
   );

   // Sweeper side
   modport slave (
      input  start_i, expected_i, q_i,
      output a_o, b_o, c_o, busy_o, done_o, table_o, mismatch_o, pass_o
   );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks {A,B,C} through 000..111, holds each SETTLE_CYCLES cycles, samples Q into an 8-bit table.
// Latency: start accepted at edge N -> busy from N; done pulses 8*SETTLE_CYCLES cycles later.
// Backpressure: start ignored while busy (no queuing). Optional compare via SWEEP_COMPARE_EN.
module truth_table_sweeper #(
   parameter int unsigned SETTLE_CYCLES = 2   // legal range 1..255
) (
   input  logic                 clk,
   input  logic                 rst,
   truth_table_sweeper_if.slave sw
);

   typedef enum logic {IDLE, SWEEP} state_t;

   localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

   state_t     state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] table_q, table_d;
   logic       done_q, done_d;

`ifdef SWEEP_COMPARE_EN
   logic [7:0] exp_q, exp_d;
   logic [7:0] mismatch_q, mismatch_d;
   logic       pass_q, pass_d;
`else
   // Reference table is unused when the comparison is compiled out.
   logic       unused_expected;
   assign unused_expected = ^sw.expected_i;
`endif

   // Next-state logic: accept start in IDLE, step the settle counter and vector index in SWEEP
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      table_d = table_q;
      done_d  = 1'b0;
`ifdef SWEEP_COMPARE_EN
      exp_d      = exp_q;
      mismatch_d = mismatch_q;
      pass_d     = pass_q;
`endif
      case (state_q)
         IDLE: begin
            if (sw.start_i) begin
               state_d = SWEEP;
               idx_d   = 3'd0;
               cnt_d   = 8'd0;
               table_d = 8'h00;
`ifdef SWEEP_COMPARE_EN
               exp_d      = sw.expected_i;
               mismatch_d = 8'h00;
               pass_d     = 1'b0;
`endif
            end
         end
         SWEEP: begin
            if (cnt_q == LAST_CNT) begin
               // Last edge of the hold window: capture Q for this vector
               cnt_d          = 8'd0;
               table_d[idx_q] = sw.q_i;
               if (idx_q == 3'd7) begin
                  state_d = IDLE;
                  idx_d   = 3'd0;
                  done_d  = 1'b1;
`ifdef SWEEP_COMPARE_EN
                  mismatch_d = table_d ^ exp_q;
                  pass_d     = (table_d == exp_q);
`endif
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset discards any partial sweep
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= 3'd0;
         cnt_q   <= 8'd0;
         table_q <= 8'h00;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         table_q <= table_d;
         done_q  <= done_d;
      end
   end

`ifdef SWEEP_COMPARE_EN
   // Reference latch and comparison results
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q      <= 8'h00;
         mismatch_q <= 8'h00;
         pass_q     <= 1'b0;
      end else begin
         exp_q      <= exp_d;
         mismatch_q <= mismatch_d;
         pass_q     <= pass_d;
      end
   end

   assign sw.mismatch_o = mismatch_q;
   assign sw.pass_o     = pass_q;
`else
   assign sw.mismatch_o = 8'h00;
   assign sw.pass_o     = 1'b0;
`endif

   // idx_q is held at zero outside a sweep, so the vector outputs read 000 in IDLE
   assign sw.a_o     = idx_q[2];
   assign sw.b_o     = idx_q[1];
   assign sw.c_o     = idx_q[0];
   assign sw.busy_o  = (state_q == SWEEP);
   assign sw.done_o  = done_q;
   assign sw.table_o = table_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: three instances (settle 2, 1, 3) driven by a Q model.
// Expected results are queued when a sweep is started and checked at its done pulse.
// Compare-output expectations follow whether SWEEP_COMPARE_EN is defined.
module tb_truth_table_sweeper;

   typedef struct {
      logic [7:0] tbl;
      logic [7:0] mm;
      logic       pass;
      int         len;
   } exp_t;

   exp_t sb[$];

   int tests_run = 0;
   int fails     = 0;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic       start_a [3];
   logic [7:0] exp_a   [3];
   logic       qmode_a [3];   // 0: Q = (A&B)|C, 1: Q tied high

   logic [2:0] abc_w  [3];
   logic       busy_w [3];
   logic       done_w [3];
   logic [7:0] tbl_w  [3];
   logic [7:0] mm_w   [3];
   logic       pass_w [3];

   truth_table_sweeper_if sw0();
   truth_table_sweeper_if sw1();
   truth_table_sweeper_if sw2();

   truth_table_sweeper #(.SETTLE_CYCLES(2)) dut0 (.clk(clk), .rst(rst), .sw(sw0));
   truth_table_sweeper #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .sw(sw1));
   truth_table_sweeper #(.SETTLE_CYCLES(3)) dut2 (.clk(clk), .rst(rst), .sw(sw2));

   assign sw0.start_i    = start_a[0];
   assign sw1.start_i    = start_a[1];
   assign sw2.start_i    = start_a[2];
   assign sw0.expected_i = exp_a[0];
   assign sw1.expected_i = exp_a[1];
   assign sw2.expected_i = exp_a[2];
   assign sw0.q_i = qmode_a[0] ? 1'b1 : ((sw0.a_o & sw0.b_o) | sw0.c_o);
   assign sw1.q_i = qmode_a[1] ? 1'b1 : ((sw1.a_o & sw1.b_o) | sw1.c_o);
   assign sw2.q_i = qmode_a[2] ? 1'b1 : ((sw2.a_o & sw2.b_o) | sw2.c_o);

   assign abc_w[0]  = {sw0.a_o, sw0.b_o, sw0.c_o};
   assign abc_w[1]  = {sw1.a_o, sw1.b_o, sw1.c_o};
   assign abc_w[2]  = {sw2.a_o, sw2.b_o, sw2.c_o};
   assign busy_w[0] = sw0.busy_o;
   assign busy_w[1] = sw1.busy_o;
   assign busy_w[2] = sw2.busy_o;
   assign done_w[0] = sw0.done_o;
   assign done_w[1] = sw1.done_o;
   assign done_w[2] = sw2.done_o;
   assign tbl_w[0]  = sw0.table_o;
   assign tbl_w[1]  = sw1.table_o;
   assign tbl_w[2]  = sw2.table_o;
   assign mm_w[0]   = sw0.mismatch_o;
   assign mm_w[1]   = sw1.mismatch_o;
   assign mm_w[2]   = sw2.mismatch_o;
   assign pass_w[0] = sw0.pass_o;
   assign pass_w[1] = sw1.pass_o;
   assign pass_w[2] = sw2.pass_o;

   always #5 clk = ~clk;

   function automatic int settle(input int k);
      if (k == 0) return 2;
      if (k == 1) return 1;
      return 3;
   endfunction

   // Reference truth table for the modelled function
   function automatic logic [7:0] model_table(input logic qmode);
      logic [7:0] t;
      logic a, b, c;
      t = 8'h00;
      for (int i = 0; i < 8; i++) begin
         a = ((i >> 2) & 1) != 0;
         b = ((i >> 1) & 1) != 0;
         c = (i & 1) != 0;
         t[i] = qmode ? 1'b1 : ((a & b) | c);
      end
      return t;
   endfunction

   function automatic exp_t make_exp(input int k, input logic [7:0] exp_in);
      exp_t e;
      e.tbl = model_table(qmode_a[k]);
`ifdef SWEEP_COMPARE_EN
      e.mm   = e.tbl ^ exp_in;
      e.pass = (e.mm == 8'h00);
`else
      e.mm   = 8'h00;
      e.pass = 1'b0;
`endif
      e.len = 8 * settle(k);
      return e;
   endfunction

   // Start one sweep on instance k and check it cycle by cycle; poke re-pulses start at vector 3
   task automatic run_sweep(input int k, input logic [7:0] exp_in, input bit poke);
      exp_t e;
      int   s;
      int   len;
      s   = settle(k);
      len = 0;
      sb.push_back(make_exp(k, exp_in));
      @(negedge clk);
      exp_a[k]   = exp_in;
      start_a[k] = 1'b1;
      @(negedge clk);
      start_a[k] = 1'b0;
      while (busy_w[k] === 1'b1 && len < 8 * s + 20) begin
         tests_run++;
         if (abc_w[k] !== 3'(len / s)) begin
            fails++;
            $display("FAIL vector k=%0d cycle=%0d got=%b exp=%b", k, len, abc_w[k], 3'(len / s));
         end
         tests_run++;
         if (done_w[k] !== 1'b0) begin
            fails++;
            $display("FAIL done_during_busy k=%0d cycle=%0d got=%b exp=0", k, len, done_w[k]);
         end
         start_a[k] = poke && (len == 3 * s);
         len++;
         @(negedge clk);
      end
      start_a[k] = 1'b0;
      e = sb.pop_front();
      tests_run++;
      if (len !== e.len) begin
         fails++;
         $display("FAIL busy_len k=%0d got=%0d exp=%0d", k, len, e.len);
      end
      tests_run++;
      if (done_w[k] !== 1'b1) begin
         fails++;
         $display("FAIL done_pulse k=%0d got=%b exp=1", k, done_w[k]);
      end
      tests_run++;
      if (tbl_w[k] !== e.tbl) begin
         fails++;
         $display("FAIL table k=%0d got=%h exp=%h", k, tbl_w[k], e.tbl);
      end
      tests_run++;
      if (mm_w[k] !== e.mm) begin
         fails++;
         $display("FAIL mismatch k=%0d got=%h exp=%h", k, mm_w[k], e.mm);
      end
      tests_run++;
      if (pass_w[k] !== e.pass) begin
         fails++;
         $display("FAIL pass k=%0d got=%b exp=%b", k, pass_w[k], e.pass);
      end
      tests_run++;
      if (abc_w[k] !== 3'b000) begin
         fails++;
         $display("FAIL idle_vector k=%0d got=%b exp=000", k, abc_w[k]);
      end
      @(negedge clk);
      tests_run++;
      if (done_w[k] !== 1'b0 || busy_w[k] !== 1'b0) begin
         fails++;
         $display("FAIL after_done k=%0d got done=%b busy=%b exp done=0 busy=0", k, done_w[k], busy_w[k]);
      end
      tests_run++;
      if (tbl_w[k] !== e.tbl) begin
         fails++;
         $display("FAIL table_hold k=%0d got=%h exp=%h", k, tbl_w[k], e.tbl);
      end
   endtask

   task automatic check_reset_values(input string tag);
      for (int k = 0; k < 3; k++) begin
         tests_run++;
         if (abc_w[k] !== 3'b000 || busy_w[k] !== 1'b0 || done_w[k] !== 1'b0 ||
             tbl_w[k] !== 8'h00 || mm_w[k] !== 8'h00 || pass_w[k] !== 1'b0) begin
            fails++;
            $display("FAIL %s k=%0d got abc=%b busy=%b done=%b tbl=%h mm=%h pass=%b exp all zero",
                     tag, k, abc_w[k], busy_w[k], done_w[k], tbl_w[k], mm_w[k], pass_w[k]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      check_reset_values("reset_state");
      rst = 1'b0;
      @(negedge clk);
      check_reset_values("idle_after_reset");
   endtask

   task automatic test_basic_sweep();
      run_sweep(0, 8'hEA, 1'b0);
   endtask

   task automatic test_settle_lengths();
      run_sweep(1, 8'hEA, 1'b0);
      run_sweep(2, 8'hEA, 1'b0);
   endtask

   task automatic test_compare();
      run_sweep(0, 8'hEA, 1'b0);
      run_sweep(0, 8'hEB, 1'b0);
      run_sweep(2, 8'h00, 1'b0);
   endtask

   task automatic test_ignored_start();
      run_sweep(0, 8'hEA, 1'b1);
      run_sweep(1, 8'hEA, 1'b1);
   endtask

   task automatic test_reset_midsweep();
      int waited;
      @(negedge clk);
      exp_a[0]   = 8'hEA;
      start_a[0] = 1'b1;
      @(negedge clk);
      start_a[0] = 1'b0;
      waited = 0;
      while (abc_w[0] !== 3'b100 && waited < 40) begin
         waited++;
         @(negedge clk);
      end
      tests_run++;
      if (abc_w[0] !== 3'b100) begin
         fails++;
         $display("FAIL reach_vector4 got=%b exp=100", abc_w[0]);
      end
      rst = 1'b1;
      @(negedge clk);
      check_reset_values("reset_midsweep");
      rst = 1'b0;
      @(negedge clk);
      check_reset_values("idle_after_midsweep_reset");
      run_sweep(0, 8'hEA, 1'b0);
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   gap;
      qmode_a[0] = 1'b1;
      for (int p = 0; p < 3; p++) sb.push_back(make_exp(0, 8'hFF));
      @(negedge clk);
      exp_a[0]   = 8'hFF;
      start_a[0] = 1'b1;
      for (int p = 0; p < 3; p++) begin
         gap = 0;
         @(negedge clk);
         gap++;
         while (done_w[0] !== 1'b1 && gap < 100) begin
            @(negedge clk);
            gap++;
         end
         if (p == 2) start_a[0] = 1'b0;
         e = sb.pop_front();
         tests_run++;
         if (done_w[0] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_done p=%0d got=%b exp=1", p, done_w[0]);
         end
         if (p > 0) begin
            tests_run++;
            if (gap !== 8 * settle(0) + 1) begin
               fails++;
               $display("FAIL b2b_spacing p=%0d got=%0d exp=%0d", p, gap, 8 * settle(0) + 1);
            end
         end
         tests_run++;
         if (tbl_w[0] !== e.tbl) begin
            fails++;
            $display("FAIL b2b_table p=%0d got=%h exp=%h", p, tbl_w[0], e.tbl);
         end
         tests_run++;
         if (pass_w[0] !== e.pass || mm_w[0] !== e.mm) begin
            fails++;
            $display("FAIL b2b_compare p=%0d got pass=%b mm=%h exp pass=%b mm=%h",
                     p, pass_w[0], mm_w[0], e.pass, e.mm);
         end
      end
      @(negedge clk);
      tests_run++;
      if (busy_w[0] !== 1'b0) begin
         fails++;
         $display("FAIL b2b_stop got busy=%b exp=0", busy_w[0]);
      end
      qmode_a[0] = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         start_a[k] = 1'b0;
         exp_a[k]   = 8'h00;
         qmode_a[k] = 1'b0;
      end
      test_reset();
      test_basic_sweep();
      test_settle_lengths();
      test_compare();
      test_ignored_start();
      test_reset_midsweep();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequencer that drives the three inputs A, B, C of a 3-input combinational function under test and walks all eight input combinations in ascending binary order. It holds each vector for a programmable settle time, samples the function's output Q and assembles the results into an 8-bit truth-table register. It replaces hand-written stimulus loops with an on-chip, handshaked sweep and sits between a control source (switch/button or host logic) and the combinational block.

## Interface
- SETTLE_CYCLES, 2, clock cycles each vector is held before Q is sampled; legal range 1..255.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a sweep; level-sampled in IDLE.
- expected  input  8  reference truth table, bit i = required Q for {A,B,C}=i; latched on accepted start.
- Q  input  1  output of the function under test.
- A  output  1  function input, MSB of vector index.
- B  output  1  function input, middle bit of vector index.
- C  output  1  function input, LSB of vector index.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- table  output  8  captured truth table, bit i = sampled Q for vector i.
- mismatch  output  8  table XOR latched expected, valid from done onward.
- pass  output  1  high when mismatch == 0 after a completed sweep.

## Operation
- States: IDLE, SWEEP.
- IDLE: {A,B,C} = 3'b000; start=1 -> SWEEP, idx=0, settle counter=0, table cleared to 8'h00, expected latched, pass/mismatch cleared to 0.
- SWEEP: {A,B,C} = idx. Settle counter increments each cycle; on the cycle it equals SETTLE_CYCLES-1, Q is written into table[idx] at that edge and the counter reset to 0.
  - idx < 7: idx increments at the same edge.
  - idx == 7: -> IDLE, done=1 for the next cycle, mismatch/pass updated at the same edge.
- start while busy is ignored; no queuing.
- start high in the cycle done is high: accepted (state is IDLE), new sweep begins; table cleared.
- start held high continuously: back-to-back sweeps, one IDLE cycle between them.
- table retains its value in IDLE until the next accepted start.
- Reset mid-sweep: immediate return to IDLE; every output returns to its reset value; partial results discarded.
- Reset values: A=B=C=0, busy=0, done=0, table=8'h00, mismatch=8'h00, pass=0.

## Timing
- start accepted at edge N -> busy=1 and {A,B,C}=000 from edge N.
- Each vector is held exactly SETTLE_CYCLES cycles; Q is sampled at the last edge of the hold window.
- busy is high for exactly 8*SETTLE_CYCLES cycles.
- done is high for exactly one cycle, coincident with busy falling; table, mismatch and pass are final in that cycle.
- Q must be stable for one clock cycle before its sample edge; settle time is the caller's choice via SETTLE_CYCLES.

## Configuration
- SWEEP_COMPARE_EN defined: expected latched on start, mismatch = table ^ expected and pass = (mismatch == 0), both updated at sweep completion.
- SWEEP_COMPARE_EN undefined: expected ignored, no latch register; mismatch held at 8'h00 and pass held at 0. Sweep, table, busy and done behave identically in both builds.

## Test plan
- Q modelled as (A&B)|C, SETTLE_CYCLES=2, pulse start -> busy high 16 cycles, {A,B,C} steps 000..111 every 2 cycles, done one pulse, table=8'hEA.
- Same model, SETTLE_CYCLES=1 and then 3 -> busy length 8 and 24 cycles respectively, table=8'hEA in both.
- With SWEEP_COMPARE_EN, expected=8'hEA -> pass=1, mismatch=8'h00; expected=8'hEB -> pass=0, mismatch=8'h01. Without the macro -> pass=0, mismatch=8'h00.
- Pulse start again at vector 3 of a running sweep -> ignored: busy length and table unchanged, single done pulse.
- Assert reset while {A,B,C}=100 -> all outputs at reset values next cycle. Next start sweeps from 000 and gives a correct table.
- Q tied 1 with start held high -> table=8'hFF, consecutive done pulses spaced 8*SETTLE_CYCLES+1 cycles apart.
